// File: rtl/de_script_player.sv
// rtl/de_script_player.sv - scripted decode stage replaying a pre-decoded instruction table into AG
//
// Purpose: holds a small table of packed, pre-decoded instructions and, after
// start_i, presents them one by one on the de_* outputs. An entry retires when
// AG accepts it (busy & ld_ag & ag_vin). After the last entry the outputs fall
// to an all-zero bubble and the block parks in DONE.
// Build option: DE_SCRIPT_LOOP_EN - replay wraps to entry 0 forever instead of
// ending in DONE, and start_i during RUN restarts the program.
//
// Ports:
//   clk_i, rst_n_i          clock (posedge), asynchronous active-low reset
//   tbl_we_i/addr_i/data_i  table write port (any state)
//   prog_len_i              program length, sampled on start (0 -> 1, >DEPTH -> DEPTH)
//   start_i                 begin replay from entry 0
//   de_v_i, reg_dep_i, mem_dep_i, mr_stall_i, mw_stall_i  pipeline valid/hazards
//   ld_ag_o, ag_vin_o       advance handshake towards AG (combinational)
//   de_*_o, ro/rm_needed_o  fields of the entry currently presented (registered)
//   busy_o, done_o          RUN / DONE state flags
//   retired_o               saturating count of entries accepted by AG
module de_script_player #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int EW    = 50 + 5 * DW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          tbl_we_i,
  input  logic [AW-1:0] tbl_addr_i,
  input  logic [EW-1:0] tbl_data_i,
  input  logic [AW:0]   prog_len_i,
  input  logic          start_i,
  input  logic          de_v_i,
  input  logic          reg_dep_i,
  input  logic          mem_dep_i,
  input  logic          mr_stall_i,
  input  logic          mw_stall_i,
  output logic          ld_ag_o,
  output logic          ag_vin_o,
  output logic          de_re_o,
  output logic          de_we_o,
  output logic          de_rmsel_o,
  output logic          ro_needed_o,
  output logic          rm_needed_o,
  output logic [1:0]    de_alusel_o,
  output logic [2:0]    de_jmp_o,
  output logic [7:0]    de_modrm_o,
  output logic [15:0]   de_sreg_o,
  output logic [15:0]   de_ptr_o,
  output logic [DW-1:0] de_dval_o,
  output logic [DW-1:0] de_sval_o,
  output logic [DW-1:0] de_disp_o,
  output logic [DW-1:0] de_flags_o,
  output logic [DW-1:0] de_flag_ld_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [15:0]   retired_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [EW-1:0] tbl_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   len_q, len_d;
  logic [EW-1:0] entry_q, entry_d;
  logic [15:0]   retired_q, retired_d;

  logic          adv;
  logic          last;
  logic          restart;
  logic [AW-1:0] ptr_nxt;
  logic [AW:0]   len_clamp;

  // Table storage is deliberately not reset so a program survives rst_n.
  always_ff @(posedge clk_i) begin
    if (tbl_we_i) begin
      tbl_q[tbl_addr_i] <= tbl_data_i;
    end
  end

  assign ld_ag_o  = ~(mem_dep_i | mr_stall_i | mw_stall_i);
  assign ag_vin_o = de_v_i & ~reg_dep_i & (state_q == RUN);
  assign busy_o   = (state_q == RUN);
  assign done_o   = (state_q == DONE);
  assign adv      = busy_o & ld_ag_o & ag_vin_o;

  assign ptr_nxt  = ptr_q + 1'b1;
  assign last     = ({1'b0, ptr_q} == (len_q - 1'b1));

  always_comb begin
    len_clamp = prog_len_i;
    if (prog_len_i == '0) begin
      len_clamp = (AW+1)'(1);
    end else if (prog_len_i > DEPTH_L) begin
      len_clamp = DEPTH_L;
    end
  end

`ifdef DE_SCRIPT_LOOP_EN
  assign restart = start_i;
`else
  assign restart = start_i & (state_q != RUN);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    entry_d   = entry_q;
    retired_d = retired_q;
    if (restart) begin
      state_d   = RUN;
      ptr_d     = '0;
      len_d     = len_clamp;
      entry_d   = tbl_q[0];
      retired_d = '0;
    end else if (adv) begin
      // Table reads here see the pre-write contents, so a same-cycle write
      // to the next slot does not leak into this load.
      if (retired_q != 16'hFFFF) begin
        retired_d = retired_q + 16'd1;
      end
      if (!last) begin
        ptr_d   = ptr_nxt;
        entry_d = tbl_q[ptr_nxt];
      end else begin
`ifdef DE_SCRIPT_LOOP_EN
        ptr_d   = '0;
        entry_d = tbl_q[0];
`else
        state_d = DONE;
        entry_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      entry_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      entry_q   <= entry_d;
      retired_q <= retired_d;
    end
  end

  assign {de_re_o, de_we_o, de_rmsel_o, de_alusel_o, de_jmp_o, de_modrm_o,
          de_sreg_o, de_ptr_o, de_dval_o, de_sval_o, de_disp_o, de_flags_o,
          de_flag_ld_o, ro_needed_o, rm_needed_o} = entry_q;

  assign retired_o = retired_q;

endmodule

// File: tb/tb_de_script_player.sv
// tb/tb_de_script_player.sv - self-checking bench for de_script_player
module tb_de_script_player;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int EW = 50 + 5 * DW;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          tbl_we_i;
  logic [AW-1:0] tbl_addr_i;
  logic [EW-1:0] tbl_data_i;
  logic [AW:0]   prog_len_i;
  logic          start_i;
  logic          de_v_i, reg_dep_i, mem_dep_i, mr_stall_i, mw_stall_i;
  logic          ld_ag_o, ag_vin_o;
  logic          de_re_o, de_we_o, de_rmsel_o, ro_needed_o, rm_needed_o;
  logic [1:0]    de_alusel_o;
  logic [2:0]    de_jmp_o;
  logic [7:0]    de_modrm_o;
  logic [15:0]   de_sreg_o, de_ptr_o;
  logic [DW-1:0] de_dval_o, de_sval_o, de_disp_o, de_flags_o, de_flag_ld_o;
  logic          busy_o, done_o;
  logic [15:0]   retired_o;

  int total = 0;
  int bad   = 0;

  de_script_player #(.DEPTH(16), .AW(AW), .DW(DW), .EW(EW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .tbl_we_i(tbl_we_i), .tbl_addr_i(tbl_addr_i), .tbl_data_i(tbl_data_i),
    .prog_len_i(prog_len_i), .start_i(start_i),
    .de_v_i(de_v_i), .reg_dep_i(reg_dep_i), .mem_dep_i(mem_dep_i),
    .mr_stall_i(mr_stall_i), .mw_stall_i(mw_stall_i),
    .ld_ag_o(ld_ag_o), .ag_vin_o(ag_vin_o),
    .de_re_o(de_re_o), .de_we_o(de_we_o), .de_rmsel_o(de_rmsel_o),
    .ro_needed_o(ro_needed_o), .rm_needed_o(rm_needed_o),
    .de_alusel_o(de_alusel_o), .de_jmp_o(de_jmp_o), .de_modrm_o(de_modrm_o),
    .de_sreg_o(de_sreg_o), .de_ptr_o(de_ptr_o),
    .de_dval_o(de_dval_o), .de_sval_o(de_sval_o), .de_disp_o(de_disp_o),
    .de_flags_o(de_flags_o), .de_flag_ld_o(de_flag_ld_o),
    .busy_o(busy_o), .done_o(done_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [4:0]  len;
    logic [4:0]  hz;      // {de_v, reg_dep, mem_dep, mr_stall, mw_stall}
    logic        x_ld;
    logic        x_agv;
    logic [31:0] x_dval;
    logic [7:0]  x_modrm;
    logic        x_busy;
    logic        x_done;
    logic [15:0] x_ret;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(logic st, logic [4:0] len, logic [4:0] hz,
                               logic ld, logic agv, logic [31:0] dval,
                               logic [7:0] modrm, logic busy, logic done,
                               logic [15:0] ret);
    vec_t v;
    v.st = st; v.len = len; v.hz = hz; v.x_ld = ld; v.x_agv = agv;
    v.x_dval = dval; v.x_modrm = modrm; v.x_busy = busy; v.x_done = done;
    v.x_ret = ret;
    return v;
  endfunction

  // ADD ECX,EAX: we=1, rmsel=1, alusel=11, modrm=C1, sval=1
  function automatic logic [EW-1:0] mk_add(int d);
    return {1'b0, 1'b1, 1'b1, 2'b11, 3'b000, 8'hC1, 16'h0, 16'h0,
            32'(d), 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0};
  endfunction

  // Every field distinct per index so a mis-sliced output shows up.
  function automatic logic [EW-1:0] mk_full(int i);
    logic [7:0] b;
    b = 8'(i);
    return {b[0], b[1], b[2], b[1:0], b[2:0], 8'hA0 + b,
            16'h1000 + {8'h0, b}, 16'h2000 + {8'h0, b},
            32'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i),
            32'h400 + 32'(i), b[0], ~b[0]};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {de_re_o, de_we_o, de_rmsel_o, de_alusel_o, de_jmp_o, de_modrm_o,
            de_sreg_o, de_ptr_o, de_dval_o, de_sval_o, de_disp_o, de_flags_o,
            de_flag_ld_o, ro_needed_o, rm_needed_o};
  endfunction

  task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(logic st, logic [4:0] len, logic [4:0] hz);
    start_i    = st;
    prog_len_i = len;
    {de_v_i, reg_dep_i, mem_dep_i, mr_stall_i, mw_stall_i} = hz;
  endtask

  task automatic wr(int a, logic [EW-1:0] d);
    tbl_we_i   = 1'b1;
    tbl_addr_i = AW'(a);
    tbl_data_i = d;
    tick();
    tbl_we_i   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    drive(1'b0, 5'd0, 5'b00000);
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  localparam logic [4:0] GO  = 5'b10000;
  localparam logic [4:0] IDL = 5'b00000;

  initial begin
    rst_n_i = 1'b0; tbl_we_i = 1'b0; tbl_addr_i = '0; tbl_data_i = '0;
    drive(1'b0, 5'd0, IDL);
    @(negedge clk_i);
    #1;
    chk("reset_entry", 256'(obs()), 256'(0));
    chk("reset_flags", {busy_o, done_o, ld_ag_o, ag_vin_o, retired_o},
        {1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
    tick();
    rst_n_i = 1'b1;
    tick();

`ifndef DE_SCRIPT_LOOP_EN
    // ---------------- table-driven handshake sequences ----------------
    wr(0, mk_add(0));
    wr(1, mk_add(1));
    //            st  len  hz        ld agv dval modrm busy done ret
    vt.push_back(mkv(1, 2, GO,       1, 0, 0, 8'h00, 0, 0, 0));
    vt.push_back(mkv(0, 2, GO,       1, 1, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, GO,       1, 1, 1, 8'hC1, 1, 0, 1));
    vt.push_back(mkv(0, 2, GO,       1, 0, 0, 8'h00, 0, 1, 2));
    vt.push_back(mkv(1, 2, GO,       1, 0, 0, 8'h00, 0, 1, 2));
    vt.push_back(mkv(0, 2, 5'b10010, 0, 1, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, 5'b10010, 0, 1, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, 5'b10010, 0, 1, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, GO,       1, 1, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, GO,       1, 1, 1, 8'hC1, 1, 0, 1));
    vt.push_back(mkv(0, 2, GO,       1, 0, 0, 8'h00, 0, 1, 2));
    vt.push_back(mkv(1, 2, GO,       1, 0, 0, 8'h00, 0, 1, 2));
    vt.push_back(mkv(0, 2, 5'b11000, 1, 0, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, 5'b11000, 1, 0, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, IDL,      1, 0, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, 5'b10100, 0, 1, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, 5'b10001, 0, 1, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(1, 1, IDL,      1, 0, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 2, GO,       1, 1, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(1, 1, GO,       1, 1, 1, 8'hC1, 1, 0, 1));
    vt.push_back(mkv(0, 2, GO,       1, 0, 0, 8'h00, 0, 1, 2));
    vt.push_back(mkv(1, 0, IDL,      1, 0, 0, 8'h00, 0, 1, 2));
    vt.push_back(mkv(0, 0, GO,       1, 1, 0, 8'hC1, 1, 0, 0));
    vt.push_back(mkv(0, 0, GO,       1, 0, 0, 8'h00, 0, 1, 1));

    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].len, vt[i].hz);
      #1;
      chk($sformatf("vec%0d", i),
          {ld_ag_o, ag_vin_o, de_dval_o, de_modrm_o, busy_o, done_o, retired_o},
          {vt[i].x_ld, vt[i].x_agv, vt[i].x_dval, vt[i].x_modrm,
           vt[i].x_busy, vt[i].x_done, vt[i].x_ret});
      chk($sformatf("vec%0d_add_fields", i),
          {de_we_o, de_rmsel_o, de_alusel_o, de_sval_o},
          (vt[i].x_busy) ? {1'b1, 1'b1, 2'b11, 32'd1} : 36'd0);
      tick();
    end
    drive(1'b0, 5'd0, IDL);

    // ---------------- full-depth program, then clamped length ----------------
    for (int i = 0; i < 16; i++) wr(i, mk_full(i));
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b1, (pass == 0) ? 5'd16 : 5'd31, GO);
      tick();
      drive(1'b0, 5'd0, GO);
      for (int k = 0; k < 16; k++) begin
        #1;
        chk($sformatf("full%0d_entry%0d", pass, k), 256'(obs()), 256'(mk_full(k)));
        chk($sformatf("full%0d_ret%0d", pass, k), 256'(retired_o), 256'(k));
        tick();
      end
      #1;
      chk($sformatf("full%0d_bubble", pass), 256'(obs()), 256'(0));
      chk($sformatf("full%0d_end", pass), {busy_o, done_o, retired_o},
          {1'b0, 1'b1, 16'd16});
    end

    // ---------------- asynchronous reset mid-RUN ----------------
    drive(1'b1, 5'd16, GO);
    tick();
    drive(1'b0, 5'd0, GO);
    repeat (5) tick();
    #1;
    chk("mid_ptr5", 256'(de_dval_o), 256'(5));
    drive(1'b0, 5'd0, IDL);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_entry", 256'(obs()), 256'(0));
    chk("async_rst_flags", {busy_o, done_o, retired_o}, {1'b0, 1'b0, 16'd0});
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    drive(1'b1, 5'd16, IDL);
    tick();
    drive(1'b0, 5'd0, GO);
    #1;
    chk("replay_e0", 256'(obs()), 256'(mk_full(0)));
    chk("replay_busy", 256'(busy_o), 256'(1));
    tick();
    #1;
    chk("replay_e1", 256'(obs()), 256'(mk_full(1)));

    // ---------------- read-before-write and write to shown entry ----------------
    do_reset();
    wr(0, mk_add(0));
    wr(1, mk_add(1));
    drive(1'b1, 5'd2, IDL);
    tick();
    drive(1'b0, 5'd0, GO);
    tbl_we_i = 1'b1; tbl_addr_i = AW'(1); tbl_data_i = mk_add(77);
    tick();
    #1;
    chk("rbw_old_value", 256'(de_dval_o), 256'(1));
    drive(1'b0, 5'd0, IDL);
    tbl_data_i = mk_add(88);
    tick();
    tbl_we_i = 1'b0;
    #1;
    chk("shown_entry_hold", 256'(de_dval_o), 256'(1));
    drive(1'b0, 5'd0, GO);
    tick();
    #1;
    chk("rbw_done", 256'(done_o), 256'(1));
    drive(1'b1, 5'd2, GO);
    tick();
    drive(1'b0, 5'd0, GO);
    tick();
    #1;
    chk("rewritten_e1", 256'(de_dval_o), 256'(88));
`else
    // ---------------- looping replay ----------------
    for (int i = 0; i < 3; i++) wr(i, mk_full(i));
    drive(1'b1, 5'd3, GO);
    tick();
    drive(1'b0, 5'd0, GO);
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("loop_entry%0d", k), 256'(obs()), 256'(mk_full(k % 3)));
      chk($sformatf("loop_state%0d", k), {busy_o, done_o, retired_o},
          {1'b1, 1'b0, 16'(k)});
      tick();
    end
    #1;
    chk("loop_after7", {busy_o, done_o, retired_o, de_dval_o},
        {1'b1, 1'b0, 16'd7, 32'd1});
    drive(1'b1, 5'd3, IDL);
    tick();
    drive(1'b0, 5'd0, IDL);
    #1;
    chk("loop_restart", {retired_o, de_dval_o, busy_o}, {16'd0, 32'd0, 1'b1});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
